// File: rtl/vu_meter_pkg.sv
// Shared constants, hold-FSM state type and bar helper for the stereo VU meter.
package vu_meter_pkg;

    localparam int LED_PER_CH   = 8;
    localparam int DB_STEP_BITS = 1;

    typedef enum logic [1:0] {
        HOLD_IDLE = 2'd0,
        HOLD_HOLD = 2'd1,
        HOLD_FALL = 2'd2
    } hold_state_e;

    // Bar of lvl lit LEDs starting at the quiet end (bit 0).
    function automatic logic [LED_PER_CH-1:0] therm(input logic [3:0] lvl);
        logic [LED_PER_CH-1:0] t;
        t = '0;
        for (int i = 0; i < LED_PER_CH; i++) begin
            t[i] = (lvl > 4'(i));
        end
        return t;
    endfunction

endpackage

// File: rtl/vu_meter_channel.sv
// One meter channel: magnitude, windowed peak, log quantiser, decay ballistics
// and, when PEAK_HOLD_EN is defined, a peak-hold dot FSM.
module vu_meter_channel
    import vu_meter_pkg::*;
#(
    parameter int d_width      = 24,
    parameter int hold_windows = 16
) (
    input  logic                  mclk,
    input  logic                  reset_n,
    input  logic                  i_dv,
    input  logic                  i_win_end,
    input  logic                  i_quant_v,
    input  logic                  i_out_v,
    input  logic [d_width-1:0]    i_data,
    output logic [LED_PER_CH-1:0] o_led
);

    localparam logic [d_width-1:0] MAG_MAX = {1'b0, {(d_width-1){1'b1}}};
    localparam logic [d_width-1:0] MAG_MIN = {1'b1, {(d_width-1){1'b0}}};

    logic [d_width-1:0]    mag, mx;
    logic [d_width-1:0]    peak_q, peak_d, win_pk_q, win_pk_d;
    logic [3:0]            lvl, disp_q, disp_d;
    logic [LED_PER_CH-1:0] led_q, led_d, dot;

    always_comb begin
        if (!i_data[d_width-1])  mag = i_data;
        else if (i_data == MAG_MIN) mag = MAG_MAX;
        else                     mag = -i_data;
        mx       = (mag > peak_q) ? mag : peak_q;
        peak_d   = peak_q;
        win_pk_d = win_pk_q;
        if (i_win_end) begin
            win_pk_d = mx;
            peak_d   = '0;
        end else if (i_dv) begin
            peak_d = mx;
        end

        // One LED per 6 dB, lowest LED eight steps below full scale.
        lvl = '0;
        for (int k = 0; k < LED_PER_CH; k++) begin
            if (win_pk_q >= (d_width'(1) << (d_width - 9 + k * DB_STEP_BITS))) lvl = lvl + 4'd1;
        end
        disp_d = disp_q;
        if (i_quant_v) disp_d = (lvl >= disp_q) ? lvl : disp_q - 4'd1;
    end

`ifdef PEAK_HOLD_EN
    // state     | meaning
    // HOLD_IDLE | no dot shown
    // HOLD_HOLD | dot frozen at hold_lvl until the timer expires
    // HOLD_FALL | dot drops one LED per window
    localparam int TW = $clog2(hold_windows + 1);
    localparam logic [TW-1:0] TMR_LOAD = TW'(hold_windows);

    hold_state_e st_q, st_d;
    logic [3:0]    hold_q, hold_d;
    logic [TW-1:0] tmr_q, tmr_d;

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            st_q   <= HOLD_IDLE;
            hold_q <= '0;
            tmr_q  <= '0;
        end else begin
            st_q   <= st_d;
            hold_q <= hold_d;
            tmr_q  <= tmr_d;
        end
    end

    always_comb begin
        st_d   = st_q;
        hold_d = hold_q;
        tmr_d  = tmr_q;
        if (i_out_v) begin
            case (st_q)
                HOLD_IDLE: if (disp_q != 4'd0) begin
                    st_d   = HOLD_HOLD;
                    hold_d = disp_q;
                    tmr_d  = TMR_LOAD;
                end
                HOLD_HOLD: if (disp_q > hold_q) begin
                    hold_d = disp_q;
                    tmr_d  = TMR_LOAD;
                end else if (tmr_q <= TW'(1)) begin
                    st_d  = HOLD_FALL;
                    tmr_d = '0;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
                HOLD_FALL: if (disp_q >= hold_q) begin
                    st_d   = HOLD_HOLD;
                    hold_d = disp_q;
                    tmr_d  = TMR_LOAD;
                end else if (hold_q <= 4'd1) begin
                    st_d   = HOLD_IDLE;
                    hold_d = '0;
                end else begin
                    hold_d = hold_q - 4'd1;
                end
                default: st_d = HOLD_IDLE;
            endcase
        end
        dot = (hold_d != 4'd0) ? (LED_PER_CH'(1) << (hold_d - 4'd1)) : '0;
    end
`else
    assign dot = '0;
`endif

    assign led_d = i_out_v ? (therm(disp_q) | dot) : led_q;

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            peak_q   <= '0;
            win_pk_q <= '0;
            disp_q   <= '0;
            led_q    <= '0;
        end else begin
            peak_q   <= peak_d;
            win_pk_q <= win_pk_d;
            disp_q   <= disp_d;
            led_q    <= led_d;
        end
    end

    assign o_led = led_q;

endmodule

// File: rtl/vu_meter.sv
// Stereo peak bar-graph meter: shared window counter and output strobe, two channels.
// Define PEAK_HOLD_EN to add a falling peak-hold dot to each bar.
module vu_meter
    import vu_meter_pkg::*;
#(
    parameter int d_width      = 24,
    parameter int window       = 1024,
    parameter int hold_windows = 16
) (
    input  logic                    mclk,
    input  logic                    reset_n,
    input  logic                    i_dv,
    input  logic [d_width-1:0]      i_l_data,
    input  logic [d_width-1:0]      i_r_data,
    output logic [2*LED_PER_CH-1:0] o_led,
    output logic                    o_win_done
);

    localparam int CW = (window > 1) ? $clog2(window) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          win_end;
    logic          quant_v_q, quant_v_d, out_v_q, out_v_d, win_done_q, win_done_d;
    logic [LED_PER_CH-1:0] l_led, r_led;

    always_comb begin
        win_end    = i_dv && (cnt_q == CW'(window - 1));
        cnt_d      = i_dv ? cnt_q + CW'(1) : cnt_q;
        quant_v_d  = win_end;
        out_v_d    = quant_v_q;
        win_done_d = out_v_q;
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            quant_v_q  <= 1'b0;
            out_v_q    <= 1'b0;
            win_done_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            quant_v_q  <= quant_v_d;
            out_v_q    <= out_v_d;
            win_done_q <= win_done_d;
        end
    end

    vu_meter_channel #(.d_width(d_width), .hold_windows(hold_windows)) u_left (
        .mclk(mclk), .reset_n(reset_n), .i_dv(i_dv), .i_win_end(win_end),
        .i_quant_v(quant_v_q), .i_out_v(out_v_q), .i_data(i_l_data), .o_led(l_led)
    );

    vu_meter_channel #(.d_width(d_width), .hold_windows(hold_windows)) u_right (
        .mclk(mclk), .reset_n(reset_n), .i_dv(i_dv), .i_win_end(win_end),
        .i_quant_v(quant_v_q), .i_out_v(out_v_q), .i_data(i_r_data), .o_led(r_led)
    );

    assign o_led      = {l_led, r_led};
    assign o_win_done = win_done_q;

endmodule

// File: tb/tb_vu_meter.sv
// Self-checking bench for vu_meter (window=4, hold_windows=2, 24-bit samples).
module tb_vu_meter;

    localparam int WIN   = 4;
    localparam int HOLDW = 2;

    logic        mclk = 1'b0;
    logic        reset_n;
    logic        i_dv;
    logic [23:0] i_l_data, i_r_data;
    logic [15:0] o_led;
    logic        o_win_done;

    always #5 mclk = ~mclk;

    vu_meter #(.d_width(24), .window(WIN), .hold_windows(HOLDW)) dut (
        .mclk(mclk), .reset_n(reset_n), .i_dv(i_dv), .i_l_data(i_l_data),
        .i_r_data(i_r_data), .o_led(o_led), .o_win_done(o_win_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: per-window peak list evaluated with plain integer arithmetic.
    int          pk[2], disp[2], hs[2], hl[2], ht[2];
    int          cnt;
    logic        s0_v, s1_v, exp_done;
    logic [15:0] s0_led, s1_led, exp_led;

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            pk[c] = 0; disp[c] = 0; hs[c] = 0; hl[c] = 0; ht[c] = 0;
        end
        cnt = 0; s0_v = 0; s1_v = 0; s0_led = 0; s1_led = 0;
        exp_done = 0; exp_led = 0;
    endtask

    function automatic int mag(input logic [23:0] x);
        int v;
        v = int'($signed(x));
        if (v < 0) v = -v;
        if (v > 8388607) v = 8388607;
        return v;
    endfunction

    task automatic close_ch(input int c, output logic [7:0] b);
        int n, lg, bar;
        lg = 0;
        while ((pk[c] >> (lg + 1)) != 0) lg++;
        n = (pk[c] < 32768) ? 0 : lg - 14;
        if (n > 8) n = 8;
        disp[c] = (n >= disp[c]) ? n : disp[c] - 1;
        bar = (1 << disp[c]) - 1;
`ifdef PEAK_HOLD_EN
        if (hs[c] == 0) begin
            if (disp[c] > 0) begin hs[c] = 1; hl[c] = disp[c]; ht[c] = HOLDW; end
        end else if (hs[c] == 1) begin
            if (disp[c] > hl[c]) begin hl[c] = disp[c]; ht[c] = HOLDW; end
            else begin ht[c]--; if (ht[c] == 0) hs[c] = 2; end
        end else begin
            if (disp[c] >= hl[c]) begin hs[c] = 1; hl[c] = disp[c]; ht[c] = HOLDW; end
            else begin hl[c]--; if (hl[c] == 0) hs[c] = 0; end
        end
        if (hl[c] > 0) bar = bar | (1 << (hl[c] - 1));
`endif
        b = bar[7:0];
    endtask

    task automatic model_edge(input logic dv, input logic [23:0] l, input logic [23:0] r);
        logic        out_v;
        logic [15:0] out_led;
        logic [7:0]  bl, br;
        out_v = s1_v; out_led = s1_led;
        s1_v = s0_v; s1_led = s0_led; s0_v = 0;
        if (dv) begin
            if (mag(l) > pk[0]) pk[0] = mag(l);
            if (mag(r) > pk[1]) pk[1] = mag(r);
            cnt++;
            if (cnt == WIN) begin
                close_ch(0, bl);
                close_ch(1, br);
                s0_v = 1; s0_led = {bl, br};
                pk[0] = 0; pk[1] = 0; cnt = 0;
            end
        end
        exp_done = out_v;
        if (out_v) exp_led = out_led;
    endtask

    // Called right after a falling edge; leaves off right after the next one.
    task automatic tick(input logic dv, input logic [23:0] l, input logic [23:0] r);
        i_dv = dv; i_l_data = l; i_r_data = r;
        @(posedge mclk);
        model_edge(dv, l, r);
        @(negedge mclk);
        check("win_done", {31'd0, o_win_done}, {31'd0, exp_done});
        check("led", {16'd0, o_led}, {16'd0, exp_led});
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("rst_led", {16'd0, o_led}, 32'd0);
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge mclk);
            i_dv = ~i_dv; i_l_data = 24'($urandom); i_r_data = 24'($urandom);
            check("rst_done", {31'd0, o_win_done}, 32'd0);
        end
        @(negedge mclk);
        i_dv = 1'b0;
        reset_n = 1'b1;
    endtask

    function automatic logic [23:0] rnd_sample();
        logic [23:0] v;
        v = 24'($urandom);
        v = v >> $urandom_range(0, 23);
        if ($urandom_range(0, 1) == 1) v = -v;
        if ($urandom_range(0, 15) == 0) v = 24'h80_0000;
        return v;
    endfunction

`ifdef PEAK_HOLD_EN
    logic [7:0] decay_tbl [10] = '{8'hFF, 8'hBF, 8'h5F, 8'h2F, 8'h17, 8'h0B, 8'h05, 8'h02, 8'h01, 8'h00};
`else
    logic [7:0] decay_tbl [10] = '{8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00};
`endif

    int pulses;

    initial begin
        reset_n = 1'b1; i_dv = 1'b0; i_l_data = '0; i_r_data = '0;
        model_reset();
        #2;
        reset_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge mclk);
            check("rst_hold_led", {16'd0, o_led}, 32'd0);
            check("rst_hold_done", {31'd0, o_win_done}, 32'd0);
            i_dv = ~i_dv; i_l_data = 24'h40_0000; i_r_data = 24'($urandom);
        end
        i_dv = 1'b0;
        reset_n = 1'b1;

        // level map
        for (int i = 0; i < 4; i++) tick(1'b1, 24'h40_0000, 24'h00_8000);
        tick(1'b0, 24'h0, 24'h0);
        tick(1'b0, 24'h0, 24'h0);
        check("lvlmap_led", {16'd0, o_led}, 32'h0000_FF01);
        check("lvlmap_done", {31'd0, o_win_done}, 32'd1);
        tick(1'b0, 24'h0, 24'h0);

        // saturation then decay
        do_reset();
        for (int i = 0; i < 4; i++) tick(1'b1, 24'h80_0000, 24'h0);
        tick(1'b0, 24'h0, 24'h0);
        tick(1'b0, 24'h0, 24'h0);
        check("sat_led", {16'd0, o_led}, 32'h0000_FF00);
        for (int w = 0; w < 10; w++) begin
            for (int i = 0; i < 4; i++) tick(1'b1, 24'h0, 24'h0);
            tick(1'b0, 24'h0, 24'h0);
            tick(1'b0, 24'h0, 24'h0);
            check("decay_left", {24'd0, o_led[15:8]}, {24'd0, decay_tbl[w]});
        end
        tick(1'b0, 24'h0, 24'h0);

        // back-to-back frames across window boundaries
        pulses = 0;
        for (int i = 0; i < 24; i++) begin
            tick(1'b1, rnd_sample(), rnd_sample());
            if (o_win_done) pulses++;
        end
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 24'h0, 24'h0);
            if (o_win_done) pulses++;
        end
        check("b2b_pulses", pulses, 32'd6);

        // random traffic with a reset in the middle of a window
        for (int i = 0; i < 400; i++) begin
            if (i == 201) do_reset();
            tick(1'($urandom_range(0, 1)), rnd_sample(), rnd_sample());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
